// File: rtl/tod_pkg.sv
// Shared definitions for the time-of-day core: field widths, limits,
// control FSM states, bus payload layouts and the display word packer.
package tod_pkg;

    localparam int unsigned HR_W    = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MS_W    = 10;
    localparam int unsigned TIME_W  = HR_W + MIN_W + SEC_W + MS_W;
    localparam int unsigned PRESC_W = 16;

    localparam int unsigned HR_MAX  = 23;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned SEC_MAX = 59;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        ERR  = 2'd2
    } tod_state_e;

    // Load request payload {hr, min, sec}
    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } tod_set_t;

    // Alarm payload {hr, min}
    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
    } tod_alarm_t;

    // Packs the 27-bit time word {hr, min, sec, ms}
    function automatic logic [TIME_W-1:0] tod_pack(
        input logic [HR_W-1:0]  hr,
        input logic [MIN_W-1:0] mn,
        input logic [SEC_W-1:0] sec,
        input logic [MS_W-1:0]  ms
    );
        return {hr, mn, sec, ms};
    endfunction

endpackage

// File: rtl/tod_hr_format.sv
// Display hour formatter: applies the DST offset (wrapping 0 -> 23) and the
// 12/24-hour presentation to a canonical hour.
//   hr_i        canonical hour 0..23
//   dst_en_i    show hour minus one, mod 24
//   mode_24h_i  1 = 0..23, 0 = 1..12
//   hr_disp_c_o display hour (combinational)
//   pm_c_o      DST-adjusted hour >= 12 (combinational)
module tod_hr_format
    import tod_pkg::*;
(
    input  logic [HR_W-1:0] hr_i,
    input  logic            dst_en_i,
    input  logic            mode_24h_i,
    output logic [HR_W-1:0] hr_disp_c_o,
    output logic            pm_c_o
);

    logic [HR_W-1:0] dst_hr;
    logic [HR_W-1:0] h12;

    always_comb begin
        dst_hr = hr_i;
        // Midnight wraps to 23 instead of decrementing, so no underflow
        if (dst_en_i) begin
            dst_hr = (hr_i == '0) ? HR_W'(HR_MAX) : hr_i - HR_W'(1);
        end
        pm_c_o = (dst_hr >= HR_W'(12));
        h12    = pm_c_o ? dst_hr - HR_W'(12) : dst_hr;
        if (h12 == '0) begin
            h12 = HR_W'(12);
        end
        hr_disp_c_o = mode_24h_i ? dst_hr : h12;
    end

endmodule

// File: rtl/tod_clock_core.sv
// Time-of-day core: canonical 24-hour hr/min/sec/ms counters advanced by a
// prescaled tick, with validated load handshake, alarm and day pulses, and a
// registered display word in 12/24-hour format with optional DST offset.
//   kh_clk, reset_n  clock, async active-low reset
//   run              advance enable (prescaler holds when low)
//   mode_24h, dst_en display controls
//   set_valid/ready  load handshake, set_time = {hr, min, sec}
//   set_err          pulse on rejected load
//   alarm_en/time    alarm compare {hr, min} -> alarm_pulse
//   day_tick         pulse on midnight rollover
//   pm, disp_time    formatted display outputs
module tod_clock_core #(
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned MS_PER_SEC = 1000,
    parameter int unsigned HR_W       = 5
) (
    input  logic        kh_clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        mode_24h,
    input  logic        dst_en,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [16:0] set_time,
    output logic        set_err,
    input  logic        alarm_en,
    input  logic [10:0] alarm_time,
    output logic        alarm_pulse,
    output logic        day_tick,
    output logic        pm,
    output logic [26:0] disp_time
);
    import tod_pkg::*;

    localparam int unsigned FLD_HR_W = tod_pkg::HR_W;

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [MS_W-1:0]     MS_LAST    = MS_W'(MS_PER_SEC - 1);
    localparam logic [SEC_W-1:0]    SEC_LAST   = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0]    MIN_LAST   = MIN_W'(MIN_MAX);
    localparam logic [HR_W-1:0]     HR_LAST    = HR_W'(HR_MAX);
    localparam logic [FLD_HR_W-1:0] SET_HR_MAX = FLD_HR_W'(HR_MAX);

    tod_state_e state_q, state_d;
    tod_set_t   ld_q, ld_d;
    tod_set_t   set_s;
    tod_alarm_t alm_s;

    logic [HR_W-1:0]    hr_q, hr_d;
    logic [MIN_W-1:0]   min_q, min_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               set_ready_q, set_ready_d;
    logic               set_err_q, set_err_d;
    logic               alarm_q, alarm_d;
    logic               day_q, day_d;
    logic               pm_q;
    logic [TIME_W-1:0]  disp_q, disp_d;

    logic               hs, set_ok, tick, commit;
    logic [FLD_HR_W-1:0] fmt_hr_c;
    logic               fmt_pm_c;

    assign set_s  = tod_set_t'(set_time);
    assign alm_s  = tod_alarm_t'(alarm_time);
    assign hs     = set_valid & set_ready_q;
    assign set_ok = (set_s.hr <= SET_HR_MAX) && (set_s.min <= MIN_LAST)
                  && (set_s.sec <= SEC_LAST);

    // Control FSM, prescaler and time counter next-state
    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        ms_d    = ms_q;
        presc_d = presc_q;
        tick    = 1'b0;
        commit  = 1'b0;
        day_d   = 1'b0;

        unique case (state_q)
            RUN: begin
                // A load request outranks a coincident tick
                if (hs) begin
                    ld_d    = set_s;
                    state_d = set_ok ? LOAD : ERR;
                end else if (run) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick    = 1'b1;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
            end
            LOAD: begin
                hr_d    = HR_W'(ld_q.hr);
                min_d   = ld_q.min;
                sec_d   = ld_q.sec;
                ms_d    = '0;
                presc_d = '0;
                commit  = 1'b1;
                state_d = RUN;
            end
            ERR: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Ripple carry ms -> sec -> min -> hr
        if (tick) begin
            if (ms_q == MS_LAST) begin
                ms_d = '0;
                if (sec_q == SEC_LAST) begin
                    sec_d = '0;
                    if (min_q == MIN_LAST) begin
                        min_d = '0;
                        if (hr_q == HR_LAST) begin
                            hr_d  = '0;
                            day_d = 1'b1;
                        end else begin
                            hr_d = hr_q + HR_W'(1);
                        end
                    end else begin
                        min_d = min_q + MIN_W'(1);
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end else begin
                ms_d = ms_q + MS_W'(1);
            end
        end
    end

    // Output next-state, derived from the time being committed this edge
    always_comb begin
        set_ready_d = (state_d == RUN);
        set_err_d   = (state_d == ERR);
        alarm_d     = alarm_en && (tick || commit)
                    && (hr_d == HR_W'(alm_s.hr)) && (min_d == alm_s.min)
                    && (sec_d == '0) && (ms_d == '0);
        disp_d      = tod_pack(fmt_hr_c, min_d, sec_d, ms_d);
    end

    tod_hr_format u_hr_format (
        .hr_i        (FLD_HR_W'(hr_d)),
        .dst_en_i    (dst_en),
        .mode_24h_i  (mode_24h),
        .hr_disp_c_o (fmt_hr_c),
        .pm_c_o      (fmt_pm_c)
    );

    always_ff @(posedge kh_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            ld_q        <= '0;
            hr_q        <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            ms_q        <= '0;
            presc_q     <= '0;
            set_ready_q <= 1'b0;
            set_err_q   <= 1'b0;
            alarm_q     <= 1'b0;
            day_q       <= 1'b0;
            pm_q        <= 1'b0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            ms_q        <= ms_d;
            presc_q     <= presc_d;
            set_ready_q <= set_ready_d;
            set_err_q   <= set_err_d;
            alarm_q     <= alarm_d;
            day_q       <= day_d;
            pm_q        <= fmt_pm_c;
            disp_q      <= disp_d;
        end
    end

    assign set_ready   = set_ready_q;
    assign set_err     = set_err_q;
    assign alarm_pulse = alarm_q;
    assign day_tick    = day_q;
    assign pm          = pm_q;
    assign disp_time   = disp_q;

endmodule

// File: tb/tb_tod_clock_core.sv
// Bench for tod_clock_core: two instances (CLK_DIV=1 and CLK_DIV=4) share
// stimulus and are compared every cycle against a milliseconds-of-day model.
module tb_tod_clock_core;

    localparam int MSP   = 10;
    localparam int DAY   = 24 * 3600 * MSP;
    localparam int P_RUN = 0;
    localparam int P_LD  = 1;
    localparam int P_ERR = 2;

    logic        kh_clk = 1'b0;
    logic        reset_n;
    logic        run, mode_24h, dst_en, set_valid, alarm_en;
    logic [16:0] set_time;
    logic [10:0] alarm_time;

    logic        rdy_a, err_a, alm_a, day_a, pm_a;
    logic [26:0] disp_a;
    logic        rdy_b, err_b, alm_b, day_b, pm_b;
    logic [26:0] disp_b;

    always #5 kh_clk = ~kh_clk;

    tod_clock_core #(.CLK_DIV(1), .MS_PER_SEC(MSP), .HR_W(5)) u_dut_a (
        .kh_clk(kh_clk), .reset_n(reset_n), .run(run), .mode_24h(mode_24h),
        .dst_en(dst_en), .set_valid(set_valid), .set_ready(rdy_a),
        .set_time(set_time), .set_err(err_a), .alarm_en(alarm_en),
        .alarm_time(alarm_time), .alarm_pulse(alm_a), .day_tick(day_a),
        .pm(pm_a), .disp_time(disp_a)
    );

    tod_clock_core #(.CLK_DIV(4), .MS_PER_SEC(MSP), .HR_W(5)) u_dut_b (
        .kh_clk(kh_clk), .reset_n(reset_n), .run(run), .mode_24h(mode_24h),
        .dst_en(dst_en), .set_valid(set_valid), .set_ready(rdy_b),
        .set_time(set_time), .set_err(err_b), .alarm_en(alarm_en),
        .alarm_time(alarm_time), .alarm_pulse(alm_b), .day_tick(day_b),
        .pm(pm_b), .disp_time(disp_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = divide-by-1, 1 = divide-by-4
    int          div_m  [2];
    int          tod_m  [2];
    int          pre_m  [2];
    int          ph_m   [2];
    int          ld_ms_m[2];
    bit          rdy_m  [2];
    bit          err_m  [2];
    bit          day_m  [2];
    bit          alm_m  [2];
    bit          pm_m   [2];
    logic [26:0] disp_m [2];

    int day_cnt_a, day_cnt_b, alm_cnt_a, alm_cnt_b, err_cnt;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            tod_m[i] = 0; pre_m[i] = 0; ph_m[i] = P_RUN; ld_ms_m[i] = 0;
            rdy_m[i] = 0; err_m[i] = 0; day_m[i] = 0; alm_m[i] = 0;
            pm_m[i] = 0; disp_m[i] = '0;
        end
    endtask

    task automatic model_step(input int i);
        int h, m, s, alarm_at, d, dh;
        day_m[i] = 0;
        alm_m[i] = 0;
        alarm_at = (int'(alarm_time[10:6]) * 60 + int'(alarm_time[5:0])) * 60 * MSP;
        case (ph_m[i])
            P_LD: begin
                tod_m[i] = ld_ms_m[i];
                pre_m[i] = 0;
                ph_m[i]  = P_RUN;
                if (alarm_en && tod_m[i] == alarm_at) alm_m[i] = 1;
            end
            P_ERR: ph_m[i] = P_RUN;
            default: begin
                if (rdy_m[i] && set_valid) begin
                    h = int'(set_time[16:12]);
                    m = int'(set_time[11:6]);
                    s = int'(set_time[5:0]);
                    if (h < 24 && m < 60 && s < 60) begin
                        ph_m[i]    = P_LD;
                        ld_ms_m[i] = ((h * 60 + m) * 60 + s) * MSP;
                    end else begin
                        ph_m[i] = P_ERR;
                    end
                end else if (run) begin
                    pre_m[i]++;
                    if (pre_m[i] == div_m[i]) begin
                        pre_m[i] = 0;
                        tod_m[i] = tod_m[i] + 1;
                        if (tod_m[i] == DAY) begin
                            tod_m[i] = 0;
                            day_m[i] = 1;
                        end
                        if (alarm_en && tod_m[i] == alarm_at) alm_m[i] = 1;
                    end
                end
            end
        endcase
        err_m[i] = (ph_m[i] == P_ERR);
        rdy_m[i] = (ph_m[i] == P_RUN);
        h  = tod_m[i] / (3600 * MSP);
        m  = (tod_m[i] / (60 * MSP)) % 60;
        s  = (tod_m[i] / MSP) % 60;
        d  = dst_en ? (h + 23) % 24 : h;
        dh = mode_24h ? d : ((d % 12 == 0) ? 12 : d % 12);
        pm_m[i]   = (d >= 12);
        disp_m[i] = {5'(dh), 6'(m), 6'(s), 10'(tod_m[i] % MSP)};
    endtask

    task automatic check_inst(input int i, input logic [26:0] dp, input logic p,
                              input logic dy, input logic al, input logic er,
                              input logic rd);
        chk_eq($sformatf("disp%0d", i),  32'(dp), 32'(disp_m[i]));
        chk_eq($sformatf("pm%0d", i),    32'(p),  32'(pm_m[i]));
        chk_eq($sformatf("day%0d", i),   32'(dy), 32'(day_m[i]));
        chk_eq($sformatf("alarm%0d", i), 32'(al), 32'(alm_m[i]));
        chk_eq($sformatf("err%0d", i),   32'(er), 32'(err_m[i]));
        chk_eq($sformatf("ready%0d", i), 32'(rd), 32'(rdy_m[i]));
    endtask

    task automatic step_cycle();
        @(posedge kh_clk);
        model_step(0);
        model_step(1);
        @(negedge kh_clk);
        check_inst(0, disp_a, pm_a, day_a, alm_a, err_a, rdy_a);
        check_inst(1, disp_b, pm_b, day_b, alm_b, err_b, rdy_b);
        day_cnt_a += int'(day_a);
        day_cnt_b += int'(day_b);
        alm_cnt_a += int'(alm_a);
        alm_cnt_b += int'(alm_b);
        err_cnt   += int'(err_a);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic do_load(input int h, input int m, input int s);
        for (int k = 0; k < 4 && !rdy_m[0]; k++) step_cycle();
        chk_eq("load_ready", 32'(rdy_a), 32'd1);
        set_time  = {5'(h), 6'(m), 6'(s)};
        set_valid = 1'b1;
        step_cycle();
        set_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_a"}, 32'({disp_a, pm_a, day_a, alm_a, err_a, rdy_a}), 32'd0);
        chk_eq({tag, "_b"}, 32'({disp_b, pm_b, day_b, alm_b, err_b, rdy_b}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] exp_w;
        int h, m, s;
        div_m[0] = 1;
        div_m[1] = 4;
        day_cnt_a = 0; day_cnt_b = 0; alm_cnt_a = 0; alm_cnt_b = 0; err_cnt = 0;
        reset_n = 1'b0; run = 1'b1; mode_24h = 1'b1; dst_en = 1'b0;
        set_valid = 1'b0; set_time = '0; alarm_en = 1'b0; alarm_time = '0;
        model_reset();

        repeat (2) @(negedge kh_clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Free run from reset, 24h mode
        run_cycles(10);
        exp_w = {5'd0, 6'd0, 6'd1, 10'd0};
        chk_eq("t10_disp", 32'(disp_a), 32'(exp_w));
        run_cycles(590);
        exp_w = {5'd0, 6'd1, 6'd0, 10'd0};
        chk_eq("t600_disp", 32'(disp_a), 32'(exp_w));

        // Midnight rollover
        do_load(23, 59, 59);
        day_cnt_a = 0; day_cnt_b = 0;
        run_cycles(50);
        chk_eq("day_once_a", 32'(day_cnt_a), 32'd1);
        chk_eq("day_once_b", 32'(day_cnt_b), 32'd1);

        // 12h / DST formatting
        mode_24h = 1'b0;
        do_load(0, 30, 0);  run_cycles(2);
        chk_eq("h12_midnight", 32'(disp_a[26:22]), 32'd12);
        chk_eq("h12_midnight_pm", 32'(pm_a), 32'd0);
        do_load(13, 0, 0);  run_cycles(2);
        chk_eq("h12_13", 32'(disp_a[26:22]), 32'd1);
        chk_eq("h12_13_pm", 32'(pm_a), 32'd1);
        dst_en = 1'b1;
        do_load(0, 10, 0);  run_cycles(2);
        chk_eq("dst_h12", 32'(disp_a[26:22]), 32'd11);
        chk_eq("dst_h12_pm", 32'(pm_a), 32'd1);
        mode_24h = 1'b1;    run_cycles(2);
        chk_eq("dst_h24", 32'(disp_a[26:22]), 32'd23);
        dst_en = 1'b0;

        // Out-of-range loads
        err_cnt = 0;
        do_load(24, 0, 0);  run_cycles(3);
        do_load(5, 60, 0);  run_cycles(3);
        chk_eq("err_pulses", 32'(err_cnt), 32'd2);

        // Alarm at 07:15
        alarm_time = {5'd7, 6'd15};
        alarm_en   = 1'b1;
        do_load(7, 14, 59);
        alm_cnt_a = 0; alm_cnt_b = 0;
        run_cycles(60);
        chk_eq("alarm_once_a", 32'(alm_cnt_a), 32'd1);
        chk_eq("alarm_once_b", 32'(alm_cnt_b), 32'd1);
        alarm_en = 1'b0;
        do_load(7, 14, 59);
        alm_cnt_a = 0; alm_cnt_b = 0;
        run_cycles(60);
        chk_eq("alarm_off_a", 32'(alm_cnt_a), 32'd0);
        chk_eq("alarm_off_b", 32'(alm_cnt_b), 32'd0);

        // Freeze mid-count
        run_cycles(5);
        run = 1'b0;  run_cycles(3);
        run = 1'b1;  run_cycles(9);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) mode_24h = ~mode_24h;
            if ($urandom_range(0, 31) == 0) dst_en = ~dst_en;
            if ($urandom_range(0, 15) == 0) alarm_en = ~alarm_en;
            set_valid = ($urandom_range(0, 39) == 0);
            if (set_valid) begin
                h = int'($urandom_range(0, 25));
                m = int'($urandom_range(0, 61));
                s = int'($urandom_range(0, 61));
                if ($urandom_range(0, 2) == 0) begin
                    s = 0;
                    alarm_time = {5'(h), 6'(m)};
                end
                set_time = {5'(h), 6'(m), 6'(s)};
            end
            step_cycle();
        end
        set_valid = 1'b0;
        run = 1'b1;

        // Reset asserted while the load is in flight
        do_load(10, 20, 30);
        reset_n = 1'b0;
        #1;
        check_all_zero("midload_rst");
        model_reset();
        @(negedge kh_clk);
        reset_n = 1'b1;
        run_cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tod_clock_core.md
Name: tod_clock_core

Overview:
Parametrised time-of-day counter; successor to the fixed 12-hour clock. Keeps canonical 24-hour time (hr/min/sec/ms) from a prescaled tick. Provides runtime 12/24-hour display mode, a wrap-safe DST offset, validated time load with handshake, an alarm match pulse and a day rollover pulse. Feeds the display/formatting path with the same 27-bit packed time word.

Parameters:
CLK_DIV, 1, kh_clk cycles per ms increment (1 = every cycle); range 1..65535
MS_PER_SEC, 1000, ms counter modulus (reduce for simulation)
HR_W, 5, hour field width (fixed minimum 5)

Ports:
kh_clk  in  1  block clock
reset_n  in  1  reset (one clock; reset is asynchronous and active-low)
run  in  1  1 = time advances; 0 = freeze (prescaler holds)
mode_24h  in  1  1 = 24-hour display, 0 = 12-hour display
dst_en  in  1  1 = displayed hour is canonical hour minus 1, mod 24
set_valid  in  1  load request
set_ready  out  1  load accepted this cycle when set_valid & set_ready
set_time  in  17  {hr[4:0], min[5:0], sec[5:0]}, canonical 24-hour
set_err  out  1  one-cycle pulse: out-of-range load rejected
alarm_en  in  1  alarm compare enable
alarm_time  in  11  {hr[4:0], min[5:0]}, canonical 24-hour
alarm_pulse  out  1  one-cycle pulse on alarm match
day_tick  out  1  one-cycle pulse on 23:59:59.last -> 00:00:00.000
pm  out  1  canonical-after-DST hour >= 12
disp_time  out  27  {hr[4:0], min[5:0], sec[5:0], ms[9:0]} display-formatted

Behaviour:
- Reset (async, reset_n low): hr=min=sec=ms=0, prescaler=0, FSM=RUN, disp_time=0 in 12h format (hr=12 if mode_24h=0 at release; during reset disp_time=0), set_err=alarm_pulse=day_tick=pm=0, set_ready=0.
- FSM states: RUN, LOAD, ERR. RUN: set_ready=1. Handshake set_valid&set_ready -> LOAD if hr<24, min<60, sec<60, else ERR. LOAD (1 cycle): writes hr/min/sec, ms=0, prescaler=0, set_ready=0, then RUN. ERR (1 cycle): set_err=1, time unchanged, set_ready=0, then RUN. Time advance is suppressed in LOAD and ERR.
- Prescaler: counts 0..CLK_DIV-1 while run=1 in RUN; ms tick when it equals CLK_DIV-1 (wraps to 0). With CLK_DIV=1 every RUN cycle with run=1 is a tick.
- On tick: ms+1; ms wraps at MS_PER_SEC-1 -> 0 and carries to sec; sec 59 -> 0 carries to min; min 59 -> 0 carries to hr; hr 23 -> 0 with day_tick=1 the same edge.
- Display hour h: d = dst_en ? (hr==0 ? 23 : hr-1) : hr. pm = (d>=12). 24h mode: disp hr=d. 12h mode: disp hr = (d mod 12), with 0 shown as 12. DST never underflows; no combinational subtract of raw hr.
- disp_time, pm registered; reflect counter state committed on the same edge (computed from next-state), zero-cycle lag vs internal registers. Mode/dst changes visible on the next edge.
- alarm_pulse: 1 for one cycle when alarm_en=1 and a tick or load makes canonical time exactly alarm hr:min:00.000. No re-fire while held. Comparison is against canonical hr, not DST hr.
- Simultaneous set_valid with a tick: load wins, tick discarded.
- run=0: all counters hold; loads are still accepted.
- Reset mid-LOAD aborts the load; time is 0.

Decomposition:
- Shared package tod_pkg: field widths (HR_W=5, MIN_W=6, SEC_W=6, MS_W=10), HR_MAX=23, MIN_MAX=59, FSM state enum {RUN, LOAD, ERR}, packing function for the 27-bit word.
- Sub-module tod_hr_format: combinational canonical hr + dst_en + mode_24h -> display hr and pm.

Test Plan:
- Reset then run with CLK_DIV=1, MS_PER_SEC=10, 24h: after 10 cycles disp_time = {0,0,1,0}; after 600 cycles min=1.
- Load 23:59:59, MS_PER_SEC=10: after 10 ticks time = 00:00:00.000, day_tick high exactly one cycle.
- 12h mode, load 00:30:00 -> disp hr=12, pm=0. Load 13:00:00 -> disp hr=1, pm=1. Set dst_en on 00:xx -> disp hr 11 (12h), 23 (24h), pm=1.
- Load set_time hr=24 -> set_err pulse, set_ready low 1 cycle, time unchanged. min=60 -> same.
- alarm_time=07:15, alarm_en=1, load 07:14:59 with MS_PER_SEC=10: alarm_pulse exactly once at 07:15:00.000. Not asserted with alarm_en=0.
- CLK_DIV=4, run toggled low for 3 cycles mid-count: ms advances every 4 active cycles; frozen cycles add nothing. Reset_n asserted mid-LOAD: all outputs 0 asynchronously.
